clock_edge_tracker: RTL and testbench

Fast-domain receiver for the divided clock and divided reset pair produced by the team's even-integer clock divider. It synchronizes both signals into the source clock domain and emits single-cycle rising and falling edge clock enables, so fast-domain logic can act on divided-clock edges without using the divided clock as a clock. It also measures each half-period, qualifies the divided clock with a lock state machine, and flags period errors and loss of clock.

---
 rtl/clock_edge_tracker_if.sv | 30 +++
 rtl/clock_edge_tracker.sv | 194 +++++++++++++++++++
 tb/tb_clock_edge_tracker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_edge_tracker_if.sv
// Divided-clock receiver bus: divided clock/reset in, fast-domain enables and status out.
interface clock_edge_tracker_if #(
  parameter int unsigned par_clk_divisor = 1000
);
  localparam int unsigned CW = $clog2(par_clk_divisor) + 1;

  logic          i_clk_div;
  logic          i_rst_div;
  logic          o_rise_ce;
  logic          o_fall_ce;
  logic          o_rst_ce;
  logic          o_locked;
  logic          o_period_err;
  logic [CW-1:0] o_half_period;
  logic [15:0]   o_err_count;

  // Source of the divided pair; consumer of the tracker status.
  modport master (
    output i_clk_div, i_rst_div,
    input  o_rise_ce, o_fall_ce, o_rst_ce, o_locked, o_period_err,
    input  o_half_period, o_err_count
  );

  // The tracker itself.
  modport slave (
    input  i_clk_div, i_rst_div,
    output o_rise_ce, o_fall_ce, o_rst_ce, o_locked, o_period_err,
    output o_half_period, o_err_count
  );
endinterface

// File: rtl/clock_edge_tracker.sv
// Fast-domain tracker for a divided clock/reset pair: synchronizes both, emits
// rise/fall clock enables, measures half-periods and qualifies lock.
// Optional error statistics counter: define CLOCK_EDGE_TRACKER_STATS_EN.
module clock_edge_tracker #(
  parameter int unsigned par_clk_divisor = 1000,
  parameter int unsigned par_sync_stages = 2,
  parameter int unsigned par_lock_count  = 4
) (
  input  logic                i_clk_mhz,
  input  logic                i_rst_mhz,
  clock_edge_tracker_if.slave bus
);
  localparam int unsigned CW = $clog2(par_clk_divisor) + 1;
  localparam int unsigned SW = par_sync_stages;
  localparam int unsigned GW = 4;

  localparam logic [CW-1:0] HALF_C = CW'(par_clk_divisor / 2);
  localparam logic [CW-1:0] FULL_C = CW'(par_clk_divisor);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [GW-1:0] LOCK_C = GW'(par_lock_count);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  logic [SW-1:0] clk_sync_d, clk_sync_q;
  logic [SW-1:0] rst_sync_d, rst_sync_q;
  logic          clk_dly_d, clk_dly_q;
  logic          rise_ce_d, rise_ce_q;
  logic          fall_ce_d, fall_ce_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          timed_out_d, timed_out_q;
  state_e        state_d, state_q;
  logic [GW-1:0] good_cnt_d, good_cnt_q;
  logic          locked_d, locked_q;
  logic          period_err_d, period_err_q;
  logic [CW-1:0] half_period_d, half_period_q;

  logic edge_seen_c;
  logic meas_good_c;
  logic timeout_c;

  // Synchronizer chains and edge detection on the last synchronized stage.
  always_comb begin
    clk_sync_d = {clk_sync_q[SW-2:0], bus.i_clk_div};
    rst_sync_d = {rst_sync_q[SW-2:0], bus.i_rst_div};
    clk_dly_d  = clk_sync_q[SW-1];
    rise_ce_d  = clk_sync_q[SW-1] & ~clk_dly_q;
    fall_ce_d  = ~clk_sync_q[SW-1] & clk_dly_q;
  end

  // Half-period counter; timeout flag keeps a saturation episode to one event.
  always_comb begin
    edge_seen_c = rise_ce_q | fall_ce_q;
    meas_good_c = (cnt_q == HALF_C);
    timeout_c   = ~edge_seen_c & (cnt_q == FULL_C) & ~timed_out_q;

    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    if (edge_seen_c) begin
      cnt_d       = ONE_C;
      timed_out_d = 1'b0;
    end else begin
      if (cnt_q != FULL_C) begin
        cnt_d = cnt_q + ONE_C;
      end
      if (cnt_q == FULL_C) begin
        timed_out_d = 1'b1;
      end
    end
  end

  // Lock qualification state machine with registered status outputs.
  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    locked_d      = locked_q;
    period_err_d  = 1'b0;
    half_period_d = half_period_q;

    case (state_q)
      ST_UNLOCKED: begin
        // First edge only opens a measurement window; its value is meaningless.
        if (edge_seen_c) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (edge_seen_c) begin
          half_period_d = cnt_q;
          if (meas_good_c) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if ((good_cnt_q + GW'(1)) == LOCK_C) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout_c) begin
          state_d    = ST_UNLOCKED;
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_seen_c) begin
          half_period_d = cnt_q;
          if (!meas_good_c) begin
            period_err_d = 1'b1;
            state_d      = ST_ACQUIRE;
            good_cnt_d   = '0;
            locked_d     = 1'b0;
          end
        end else if (timeout_c) begin
          period_err_d = 1'b1;
          state_d      = ST_UNLOCKED;
          good_cnt_d   = '0;
          locked_d     = 1'b0;
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = '0;
        locked_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
    if (!i_rst_mhz) begin
      clk_sync_q    <= '0;
      rst_sync_q    <= '1;
      clk_dly_q     <= 1'b0;
      rise_ce_q     <= 1'b0;
      fall_ce_q     <= 1'b0;
      cnt_q         <= '0;
      timed_out_q   <= 1'b0;
      state_q       <= ST_UNLOCKED;
      good_cnt_q    <= '0;
      locked_q      <= 1'b0;
      period_err_q  <= 1'b0;
      half_period_q <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      rst_sync_q    <= rst_sync_d;
      clk_dly_q     <= clk_dly_d;
      rise_ce_q     <= rise_ce_d;
      fall_ce_q     <= fall_ce_d;
      cnt_q         <= cnt_d;
      timed_out_q   <= timed_out_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      period_err_q  <= period_err_d;
      half_period_q <= half_period_d;
    end
  end

`ifdef CLOCK_EDGE_TRACKER_STATS_EN
  logic [15:0] err_count_d, err_count_q;

  // Saturating count of period error pulses; cleared only by the source reset.
  always_comb begin
    err_count_d = err_count_q;
    if (period_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
    if (!i_rst_mhz) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.o_err_count = err_count_q;
`else
  assign bus.o_err_count = 16'h0000;
`endif

  assign bus.o_rise_ce     = rise_ce_q;
  assign bus.o_fall_ce     = fall_ce_q;
  assign bus.o_rst_ce      = rst_sync_q[SW-1];
  assign bus.o_locked      = locked_q;
  assign bus.o_period_err  = period_err_q;
  assign bus.o_half_period = half_period_q;
endmodule

// File: tb/tb_clock_edge_tracker.sv
// Scoreboard bench for clock_edge_tracker with H=4, two sync stages, lock after 4.
`timescale 1ns/1ps
module tb_clock_edge_tracker;
  localparam int unsigned DIV  = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned LOCK = 4;
`ifdef CLOCK_EDGE_TRACKER_STATS_EN
  localparam int EXP_ERRS = 3;
`else
  localparam int EXP_ERRS = 0;
`endif

  typedef struct {
    int   cyc;
    logic rise;
    logic fall;
    logic locked;
    int   hp;
    logic err;
  } edge_t;

  typedef struct {
    int   cyc;
    logic lvl;
  } rst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  edge_t edge_q[$];
  int    timeout_q[$];
  rst_t  rst_q[$];

  edge_t pend_item;
  bit    pend = 1'b0;
  bit    err_used;
  logic  rst_prev = 1'b1;
  int    last_toggle = 0;

  clock_edge_tracker_if #(.par_clk_divisor(DIV)) bus();

  clock_edge_tracker #(
    .par_clk_divisor(DIV),
    .par_sync_stages(SYNC),
    .par_lock_count (LOCK)
  ) dut (
    .i_clk_mhz(clk),
    .i_rst_mhz(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name, input int act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event with value %0d, expected none (cycle %0d)", name, act, cyc);
  endtask

  // Toggle the divided clock after gap cycles and queue the expected strobe/status.
  task automatic do_edge(input int gap, input logic lk, input int hp, input logic er);
    logic lvl;
    repeat (gap) @(negedge clk);
    lvl = ~bus.i_clk_div;
    bus.i_clk_div = lvl;
    last_toggle = cyc;
    edge_q.push_back('{cyc + 3, lvl, ~lvl, lk, hp, er});
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe, error or rst_ce change.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      rst_prev = 1'b1;
    end else begin
      err_used = 1'b0;
      if (pend) begin
        chk("locked_after_edge", int'(bus.o_locked), int'(pend_item.locked));
        chk("half_period", int'(bus.o_half_period), pend_item.hp);
        chk("period_err_on_edge", int'(bus.o_period_err), int'(pend_item.err));
        err_used = 1'b1;
        pend     = 1'b0;
      end
      if (bus.o_rise_ce || bus.o_fall_ce) begin
        if (edge_q.size() == 0) begin
          fail_unexpected("unexpected_strobe", cyc);
        end else begin
          pend_item = edge_q.pop_front();
          chk("strobe_cycle", cyc, pend_item.cyc);
          chk("rise_ce", int'(bus.o_rise_ce), int'(pend_item.rise));
          chk("fall_ce", int'(bus.o_fall_ce), int'(pend_item.fall));
          pend = 1'b1;
        end
      end
      if (bus.o_period_err && !err_used) begin
        if (timeout_q.size() == 0) fail_unexpected("unexpected_period_err", cyc);
        else chk("timeout_err_cycle", cyc, timeout_q.pop_front());
      end
      if (bus.o_rst_ce !== rst_prev) begin
        if (rst_q.size() == 0) begin
          fail_unexpected("unexpected_rst_ce_change", int'(bus.o_rst_ce));
        end else begin
          rst_t r;
          r = rst_q.pop_front();
          chk("rst_ce_cycle", cyc, r.cyc);
          chk("rst_ce_level", int'(bus.o_rst_ce), int'(r.lvl));
        end
        rst_prev = bus.o_rst_ce;
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Steady-clock half-period pattern with expected status after each edge.
  int   gaps[18]   = '{4, 4, 4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 8, 4, 4, 4, 4, 4};
  logic lk_exp[18] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
  int   hp_exp[18] = '{0, 4, 4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 8, 4, 4, 4, 4, 4};
  logic er_exp[18] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    bus.i_clk_div = 1'b0;
    bus.i_rst_div = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_rise_ce", int'(bus.o_rise_ce), 0);
    chk("reset_fall_ce", int'(bus.o_fall_ce), 0);
    chk("reset_rst_ce", int'(bus.o_rst_ce), 1);
    chk("reset_locked", int'(bus.o_locked), 0);
    chk("reset_period_err", int'(bus.o_period_err), 0);
    chk("reset_half_period", int'(bus.o_half_period), 0);
    chk("reset_err_count", int'(bus.o_err_count), 0);

    rst_n = 1'b1;
    rst_q.push_back('{cyc + 2, 1'b0});

    // Lock, long half-period, relock, edge exactly at 2H, relock.
    for (int i = 0; i < 18; i++) do_edge(gaps[i], lk_exp[i], hp_exp[i], er_exp[i]);

    // Clock stops while locked: one timeout pulse, then silence.
    timeout_q.push_back(last_toggle + 12);
    do_edge(30, 1'b0, 4, 1'b0);
    do_edge(6, 1'b0, 6, 1'b0);

    // Reacquire while the divided reset is held high for 20 cycles.
    fork
      begin
        do_edge(4, 1'b0, 4, 1'b0);
        do_edge(4, 1'b0, 4, 1'b0);
        do_edge(4, 1'b0, 4, 1'b0);
        do_edge(4, 1'b1, 4, 1'b0);
        do_edge(4, 1'b1, 4, 1'b0);
      end
      begin
        @(negedge clk);
        bus.i_rst_div = 1'b1;
        rst_q.push_back('{cyc + 2, 1'b1});
        repeat (20) @(negedge clk);
        bus.i_rst_div = 1'b0;
        rst_q.push_back('{cyc + 2, 1'b0});
      end
    join

    repeat (6) @(negedge clk);
    chk("locked_before_reset", int'(bus.o_locked), 1);
    chk("err_count", int'(bus.o_err_count), EXP_ERRS);

    // Asynchronous source reset mid-lock.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rise_ce", int'(bus.o_rise_ce), 0);
    chk("async_rst_fall_ce", int'(bus.o_fall_ce), 0);
    chk("async_rst_rst_ce", int'(bus.o_rst_ce), 1);
    chk("async_rst_locked", int'(bus.o_locked), 0);
    chk("async_rst_period_err", int'(bus.o_period_err), 0);
    chk("async_rst_half_period", int'(bus.o_half_period), 0);
    chk("async_rst_err_count", int'(bus.o_err_count), 0);
    bus.i_clk_div = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rst_q.push_back('{cyc + 2, 1'b0});
    @(negedge clk);
    chk("post_release_rise_ce", int'(bus.o_rise_ce), 0);
    chk("post_release_fall_ce", int'(bus.o_fall_ce), 0);
    repeat (10) @(negedge clk);

    chk("edge_queue_drained", edge_q.size(), 0);
    chk("timeout_queue_drained", timeout_q.size(), 0);
    chk("rst_queue_drained", rst_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
